// File: rtl/tea_decrypt.sv
// Iterative TEA decryption core. Runs NUM_ROUNDS inverse rounds, one per
// clock, on a latched ciphertext block and key. The start/done level
// handshake matches the tea_encrypt engine so both share one wrapper.
module tea_decrypt #(
  parameter int          NUM_ROUNDS = 32,
  parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] v0_in,
  input  logic [31:0] v1_in,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out,
  output logic        done,
  output logic        busy
);

  // The key schedule runs backwards from DELTA*NUM_ROUNDS (mod 2^32).
  localparam logic [31:0] ROUNDS_32 = 32'(NUM_ROUNDS);
  localparam logic [31:0] SUM_INIT  = DELTA * ROUNDS_32;
  localparam logic [5:0]  LAST      = 6'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PROCESS = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t      state, state_next;
  logic [31:0] v0, v1, sum;
  logic [31:0] k0_r, k1_r, k2_r, k3_r;
  logic [5:0]  cnt;
  logic [31:0] v0_nxt, v1_nxt;

  // TEA mixing term shared by both half-rounds.
  function automatic logic [31:0] mix(input logic [31:0] v, input logic [31:0] s,
                                      input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // One inverse round: undo the v1 half first, then v0 using the new v1.
  always_comb begin
    v1_nxt = v1 - mix(v0, sum, k2_r, k3_r);
    v0_nxt = v0 - mix(v1_nxt, sum, k0_r, k1_r);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the unused code 11 falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = PROCESS;
      PROCESS: if (cnt == LAST) state_next = DONE;
      DONE:    if (!start)      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Datapath: latch the block on launch, iterate rounds, publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0     <= '0;
      v1     <= '0;
      sum    <= '0;
      cnt    <= '0;
      k0_r   <= '0;
      k1_r   <= '0;
      k2_r   <= '0;
      k3_r   <= '0;
      v0_out <= '0;
      v1_out <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            v0   <= v0_in;
            v1   <= v1_in;
            k0_r <= k0;
            k1_r <= k1;
            k2_r <= k2;
            k3_r <= k3;
            sum  <= SUM_INIT;
            cnt  <= '0;
          end
        end
        PROCESS: begin
          if (cnt == LAST) begin
            v0_out <= v0;
            v1_out <= v1;
            done   <= 1'b1;
          end else begin
            v0  <= v0_nxt;
            v1  <= v1_nxt;
            sum <= sum - DELTA;
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (!start) done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
